// File: rtl/secded_pkg.sv
// SEC-DED Hamming helpers shared by the protected memory and its decoders.
// Codeword layout: bit 0 = overall parity over bits 1..CW-1; bits 1..CW-1 are
// Hamming positions with parity at powers of two and data LSB-first elsewhere.
// The functions work on fixed maximum-width vectors so that any supported
// DATA_W (up to MAX_DATA_W) can share them; callers cast to their own widths.
package secded_pkg;

   localparam int unsigned MAX_DATA_W = 64;
   localparam int unsigned MAX_CW     = 72;  // 64 data + 7 Hamming + 1 overall

   typedef enum logic [1:0] {
      CLEAN  = 2'd0,
      SINGLE = 2'd1,
      DOUBLE = 2'd2
   } secded_status_e;

   // Smallest p with 2^p >= data_w + p + 1.
   function automatic int unsigned calc_p(input int unsigned data_w);
      int unsigned p;
      p = 0;
      for (int unsigned i = 1; i <= 8; i++) begin
         if (p == 0 && (32'd1 << i) >= data_w + i + 1) p = i;
      end
      return p;
   endfunction

   function automatic int unsigned calc_cw(input int unsigned data_w);
      return data_w + calc_p(data_w) + 1;
   endfunction

   // Hamming parity positions are the powers of two.
   function automatic logic is_pow2(input int unsigned pos);
      return (pos & (pos - 1)) == 0;
   endfunction

   // Places data LSB-first into the non-power-of-two positions, then fills
   // the Hamming parity bits and finally the overall parity bit 0.
   function automatic logic [MAX_CW-1:0] secded_encode(input logic [MAX_DATA_W-1:0] data,
                                                        input int unsigned         data_w);
      logic [MAX_CW-1:0] cw;
      logic              par;
      int unsigned       cw_w;
      int unsigned       p;
      int unsigned       j;
      p    = calc_p(data_w);
      cw_w = data_w + p + 1;
      cw   = '0;
      j    = 0;
      for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
         if (pos < cw_w && !is_pow2(pos)) begin
            if (j < MAX_DATA_W) cw[pos] = data[j];
            j++;
         end
      end
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < p) begin
            par = 1'b0;
            for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
               if (pos < cw_w && ((pos >> i) & 1) == 1) par = par ^ cw[pos];
            end
            cw[32'd1 << i] = par;
         end
      end
      cw[0] = ^cw;
      return cw;
   endfunction

   // Pulls the data bits back out of a (possibly corrected) codeword.
   function automatic logic [MAX_DATA_W-1:0] secded_extract(input logic [MAX_CW-1:0] cw,
                                                            input int unsigned     data_w);
      logic [MAX_DATA_W-1:0] d;
      int unsigned           cw_w;
      int unsigned           j;
      cw_w = calc_cw(data_w);
      d    = '0;
      j    = 0;
      for (int unsigned pos = 1; pos < MAX_CW; pos++) begin
         if (pos < cw_w && !is_pow2(pos)) begin
            if (j < MAX_DATA_W) d[j] = cw[pos];
            j++;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/secded_decoder.sv
// Combinational SEC-DED decoder.
// Ports:
//   cw     in  CW      raw codeword
//   data   out DATA_W  corrected data (raw data bits on uncorrectable error)
//   status out 2       CLEAN / SINGLE / DOUBLE
module secded_decoder
   import secded_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   localparam int unsigned P     = calc_p(DATA_W),
   localparam int unsigned CW    = DATA_W + P + 1
) (
   input  logic [CW-1:0]     cw,
   output logic [DATA_W-1:0] data,
   output secded_status_e    status
);

   logic [P-1:0]  syn;
   logic          ovr;
   logic [CW-1:0] fixed;

   // Syndrome is the XOR of the positions holding a one; zero for a clean word.
   always_comb begin
      syn = '0;
      for (int unsigned pos = 1; pos < CW; pos++) begin
         if (cw[pos]) syn = syn ^ P'(pos);
      end
      ovr    = ^cw;
      fixed  = cw;
      status = CLEAN;
      if (syn == '0) begin
         // Only the overall parity bit flipped; data bits are intact.
         if (ovr) status = SINGLE;
      end else if (ovr && 32'(syn) < CW) begin
         status     = SINGLE;
         fixed[syn] = ~cw[syn];
      end else begin
         // Even flip count, or a syndrome pointing past the codeword.
         status = DOUBLE;
      end
      data = DATA_W'(secded_extract(MAX_CW'(fixed), DATA_W));
   end

endmodule

// File: rtl/mem_secded_scrub.sv
// SEC-DED protected register-file memory with idle-time scrubber and
// saturating error statistics.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   wr_en         write encoded data_in to addr
//   rd_en         read addr (result one cycle later)
//   inj_en        fault injection: mem[addr] ^= inj_mask
//   addr          host address
//   data_in       write data
//   inj_mask      raw codeword XOR mask
//   scrub_en      enable background scrubber
//   cnt_clr       synchronous clear of both counters
//   data_out      corrected read data (holds when rd_valid=0)
//   rd_valid      read result valid pulse
//   err_single    corrected error on this read
//   err_double    uncorrectable error on this read
//   corr_cnt      corrected errors seen (host + scrub), saturating
//   uncorr_cnt    uncorrectable errors seen (host + scrub), saturating
//   scrub_busy    scrubber in READ or FIX
module mem_secded_scrub
   import secded_pkg::*;
#(
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned SCRUB_INTERVAL = 64,
   parameter int unsigned CNT_W          = 8,
   localparam int unsigned P             = calc_p(DATA_W),
   localparam int unsigned CW            = DATA_W + P + 1,
   localparam int unsigned AW            = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              inj_en,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic [CW-1:0]     inj_mask,
   input  logic              scrub_en,
   input  logic              cnt_clr,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              err_single,
   output logic              err_double,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt,
   output logic              scrub_busy
);

   localparam int unsigned TW = $clog2(SCRUB_INTERVAL + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_FIX  = 2'd2
   } scrub_state_e;

   logic [CW-1:0]     mem [DEPTH];

   logic              host_wr;
   logic              host_inj;
   logic              host_rd;
   logic              host_any;

   logic [DATA_W-1:0] host_data;
   secded_status_e    host_status;
   logic [DATA_W-1:0] scrub_data;
   secded_status_e    scrub_status;

   scrub_state_e      state;
   logic [TW-1:0]     timer;
   logic [AW-1:0]     scrub_ptr;
   logic              fix_pend;
   logic [DATA_W-1:0] fix_data;

   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [CW-1:0]     mem_wdata;

   logic [1:0]        corr_inc;
   logic [1:0]        uncorr_inc;

   // Only the highest-priority host operation is performed each cycle.
   assign host_wr  = wr_en;
   assign host_inj = !wr_en && inj_en;
   assign host_rd  = !wr_en && !inj_en && rd_en;
   assign host_any = wr_en || inj_en || rd_en;

   secded_decoder #(.DATA_W(DATA_W)) u_host_dec (
      .cw     (mem[addr]),
      .data   (host_data),
      .status (host_status)
   );

   secded_decoder #(.DATA_W(DATA_W)) u_scrub_dec (
      .cw     (mem[scrub_ptr]),
      .data   (scrub_data),
      .status (scrub_status)
   );

   // Single write port: host write/inject, else the scrubber's repair.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = addr;
      mem_wdata = '0;
      if (host_wr) begin
         mem_we    = 1'b1;
         mem_wdata = CW'(secded_encode(MAX_DATA_W'(data_in), DATA_W));
      end else if (host_inj) begin
         mem_we    = 1'b1;
         mem_wdata = mem[addr] ^ inj_mask;
      end else if (state == S_FIX && fix_pend && !host_any) begin
         mem_we    = 1'b1;
         mem_waddr = scrub_ptr;
         mem_wdata = CW'(secded_encode(MAX_DATA_W'(fix_data), DATA_W));
      end
   end

   // Storage; reset leaves every word as the all-zero (valid) codeword.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Host read result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out   <= '0;
         rd_valid   <= 1'b0;
         err_single <= 1'b0;
         err_double <= 1'b0;
      end else begin
         rd_valid   <= host_rd;
         err_single <= host_rd && host_status == SINGLE;
         err_double <= host_rd && host_status == DOUBLE;
         if (host_rd) data_out <= host_data;
      end
   end

   // Scrubber: wait out the idle interval, read one word, repair it if needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         timer      <= '0;
         scrub_ptr  <= '0;
         fix_pend   <= 1'b0;
         fix_data   <= '0;
         scrub_busy <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (scrub_en) begin
                  if (timer == TW'(SCRUB_INTERVAL)) begin
                     if (!host_any) begin
                        state      <= S_READ;
                        scrub_busy <= 1'b1;
                     end
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
            end
            S_READ: begin
               state    <= S_FIX;
               fix_data <= scrub_data;
               // A host write/inject to the same word makes the snapshot stale.
               fix_pend <= scrub_status == SINGLE &&
                           !((wr_en || inj_en) && addr == scrub_ptr);
            end
            S_FIX: begin
               state      <= S_IDLE;
               scrub_busy <= 1'b0;
               timer      <= '0;
               fix_pend   <= 1'b0;
               scrub_ptr  <= scrub_ptr + AW'(1);
            end
            default: begin
               state      <= S_IDLE;
               scrub_busy <= 1'b0;
            end
         endcase
      end
   end

   // Host and scrub detections in the same cycle both count.
   assign corr_inc   = 2'(host_rd && host_status == SINGLE) +
                       2'(state == S_READ && scrub_status == SINGLE);
   assign uncorr_inc = 2'(host_rd && host_status == DOUBLE) +
                       2'(state == S_READ && scrub_status == DOUBLE);

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, c} + (CNT_W + 1)'(inc);
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   // Error statistics; clear beats a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (cnt_clr) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else begin
         corr_cnt   <= sat_add(corr_cnt, corr_inc);
         uncorr_cnt <= sat_add(uncorr_cnt, uncorr_inc);
      end
   end

endmodule

// File: tb/tb_mem_secded_scrub.sv
// Bench for mem_secded_scrub: directed scenarios followed by random host
// traffic, checked against a data + flipped-bit model of each word.
module tb_mem_secded_scrub;

   localparam int unsigned DATA_W         = 8;
   localparam int unsigned DEPTH          = 16;
   localparam int unsigned SCRUB_INTERVAL = 4;
   localparam int unsigned CNT_W          = 2;
   localparam int unsigned CW             = 13;
   localparam int unsigned AW             = 4;
   localparam int          CNT_MAX        = 3;

   logic              clk;
   logic              rst;
   logic              wr_en;
   logic              rd_en;
   logic              inj_en;
   logic [AW-1:0]     addr;
   logic [DATA_W-1:0] data_in;
   logic [CW-1:0]     inj_mask;
   logic              scrub_en;
   logic              cnt_clr;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic              err_single;
   logic              err_double;
   logic [CNT_W-1:0]  corr_cnt;
   logic [CNT_W-1:0]  uncorr_cnt;
   logic              scrub_busy;

   mem_secded_scrub #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .SCRUB_INTERVAL(SCRUB_INTERVAL), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .inj_en(inj_en),
      .addr(addr), .data_in(data_in), .inj_mask(inj_mask), .scrub_en(scrub_en),
      .cnt_clr(cnt_clr), .data_out(data_out), .rd_valid(rd_valid),
      .err_single(err_single), .err_double(err_double), .corr_cnt(corr_cnt),
      .uncorr_cnt(uncorr_cnt), .scrub_busy(scrub_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Model: each word is its stored data plus the set of codeword bits flipped since.
   logic [DATA_W-1:0] m_data [DEPTH];
   logic [CW-1:0]     m_flip [DEPTH];
   int                m_corr;
   int                m_uncorr;
   logic [DATA_W-1:0] m_dout;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   // Data bits are the codeword positions 1..CW-1 that are not powers of two.
   function automatic logic [DATA_W-1:0] data_bits(input logic [CW-1:0] f);
      logic [DATA_W-1:0] d;
      int j;
      d = '0;
      j = 0;
      for (int pos = 1; pos < CW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            d[j] = f[pos];
            j++;
         end
      end
      return d;
   endfunction

   task automatic idle_inputs();
      wr_en = 0; rd_en = 0; inj_en = 0; cnt_clr = 0;
      addr = '0; data_in = '0; inj_mask = '0;
   endtask

   task automatic chk_counters(input string tag);
      chk($sformatf("%s.corr_cnt", tag), 32'(corr_cnt), 32'(m_corr));
      chk($sformatf("%s.uncorr_cnt", tag), 32'(uncorr_cnt), 32'(m_uncorr));
   endtask

   // One host cycle: drive, predict, clock, compare every read-side output.
   task automatic host_cycle(input logic w, input logic i, input logic r, input logic c,
                             input logic [AW-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [CW-1:0] m, input string tag);
      logic exp_v, exp_s, exp_d;
      int   nf, ci, ui;
      wr_en = w; inj_en = i; rd_en = r; cnt_clr = c;
      addr = a; data_in = d; inj_mask = m;
      exp_v = 0; exp_s = 0; exp_d = 0; ci = 0; ui = 0;
      if (w) begin
         m_data[a] = d;
         m_flip[a] = '0;
      end else if (i) begin
         m_flip[a] = m_flip[a] ^ m;
      end else if (r) begin
         nf    = $countones(m_flip[a]);
         exp_v = 1;
         if (nf == 0) begin
            m_dout = m_data[a];
         end else if (nf == 1) begin
            m_dout = m_data[a]; exp_s = 1; ci = 1;
         end else begin
            m_dout = m_data[a] ^ data_bits(m_flip[a]); exp_d = 1; ui = 1;
         end
      end
      m_corr   = c ? 0 : sat(m_corr + ci);
      m_uncorr = c ? 0 : sat(m_uncorr + ui);
      @(posedge clk); #1;
      chk($sformatf("%s.rd_valid", tag), 32'(rd_valid), 32'(exp_v));
      chk($sformatf("%s.err_single", tag), 32'(err_single), 32'(exp_s));
      chk($sformatf("%s.err_double", tag), 32'(err_double), 32'(exp_d));
      chk($sformatf("%s.data_out", tag), 32'(data_out), 32'(m_dout));
      chk_counters(tag);
      idle_inputs();
   endtask

   task automatic do_reset(input string tag);
      rst = 1; scrub_en = 0;
      idle_inputs();
      #2;
      for (int k = 0; k < DEPTH; k++) begin
         m_data[k] = '0;
         m_flip[k] = '0;
      end
      m_corr = 0; m_uncorr = 0; m_dout = '0;
      chk($sformatf("%s.data_out", tag), 32'(data_out), 0);
      chk($sformatf("%s.rd_valid", tag), 32'(rd_valid), 0);
      chk($sformatf("%s.err_single", tag), 32'(err_single), 0);
      chk($sformatf("%s.err_double", tag), 32'(err_double), 0);
      chk($sformatf("%s.scrub_busy", tag), 32'(scrub_busy), 0);
      chk_counters(tag);
      @(posedge clk); #1;
      rst = 0;
   endtask

   // Run with scrub_en=1 until the scrubber reports busy (bounded); lands in READ.
   task automatic wait_busy(input string tag);
      bit seen;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(posedge clk); #1;
         if (scrub_busy) seen = 1;
      end
      chk($sformatf("%s.busy_start", tag), 32'(seen), 1);
   endtask

   initial begin
      bit busy_seen, flag_seen;
      do_reset("reset0");

      // Basic write/read and single/double error reporting.
      host_cycle(1, 0, 0, 0, 4'd3, 8'hA5, '0, "wr3");
      host_cycle(0, 0, 1, 0, 4'd3, '0, '0, "rd3_clean");
      host_cycle(0, 1, 0, 0, 4'd3, '0, 13'h020, "inj020");
      host_cycle(0, 0, 1, 0, 4'd3, '0, '0, "rd3_single_data");
      host_cycle(1, 0, 0, 0, 4'd3, 8'hA5, '0, "wr3b");
      host_cycle(0, 1, 0, 0, 4'd3, '0, 13'h001, "inj001");
      host_cycle(0, 0, 1, 0, 4'd3, '0, '0, "rd3_single_p0");
      host_cycle(1, 0, 0, 0, 4'd3, 8'hA5, '0, "wr3c");
      host_cycle(0, 1, 0, 0, 4'd3, '0, 13'h006, "inj006");
      host_cycle(0, 0, 1, 0, 4'd3, '0, '0, "rd3_double");
      host_cycle(1, 0, 0, 0, 4'd9, '0, '0, "wr9_zero");
      host_cycle(0, 1, 0, 0, 4'd9, '0, 13'h0C0, "inj9_dbl_data");
      host_cycle(0, 0, 1, 0, 4'd9, '0, '0, "rd9_double_raw");

      // Counter saturation, then clear racing a detection.
      host_cycle(1, 0, 0, 0, 4'd5, 8'h3C, '0, "wr5");
      host_cycle(0, 1, 0, 0, 4'd5, '0, 13'h800, "inj5");
      for (int k = 0; k < 4; k++) host_cycle(0, 0, 1, 0, 4'd5, '0, '0, "rd5_sat");
      host_cycle(0, 0, 1, 1, 4'd5, '0, '0, "rd5_clr");

      // Host priority: write beats inject beats read.
      host_cycle(1, 1, 1, 0, 4'd2, 8'h96, 13'h010, "prio_wr");
      host_cycle(0, 1, 1, 0, 4'd2, '0, 13'h010, "prio_inj");
      host_cycle(0, 0, 1, 0, 4'd2, '0, '0, "prio_rd");

      // Background scrub repairs a single-bit error without host involvement.
      do_reset("reset_scrub");
      host_cycle(1, 0, 0, 0, 4'd7, 8'h3C, '0, "s_wr7");
      host_cycle(0, 1, 0, 0, 4'd7, '0, 13'h040, "s_inj7");
      scrub_en = 1; busy_seen = 0; flag_seen = 0;
      repeat (DEPTH * 7) begin
         @(posedge clk); #1;
         busy_seen = busy_seen | scrub_busy;
         flag_seen = flag_seen | rd_valid | err_single | err_double;
      end
      scrub_en = 0;
      repeat (4) @(posedge clk);
      #1;
      for (int k = 0; k < DEPTH; k++) begin
         if ($countones(m_flip[k]) == 1) begin
            m_flip[k] = '0;
            m_corr    = sat(m_corr + 1);
         end
      end
      chk("scrub.busy_seen", 32'(busy_seen), 1);
      chk("scrub.no_host_flags", 32'(flag_seen), 0);
      chk("scrub.idle_after", 32'(scrub_busy), 0);
      chk_counters("scrub");
      host_cycle(0, 0, 1, 0, 4'd7, '0, '0, "scrub_rd7");

      // Reset arriving in FIX aborts the repair and clears everything.
      do_reset("reset_fix");
      host_cycle(1, 0, 0, 0, 4'd0, 8'h5A, '0, "f_wr0");
      host_cycle(0, 1, 0, 0, 4'd0, '0, 13'h100, "f_inj0");
      scrub_en = 1;
      wait_busy("fixrst");
      @(posedge clk); #1;
      m_corr = sat(m_corr + 1);
      chk("fixrst.busy_in_fix", 32'(scrub_busy), 1);
      chk_counters("fixrst.pre");
      do_reset("fixrst.rst");
      host_cycle(0, 0, 1, 0, 4'd0, '0, '0, "fixrst_rd0");

      // Host write to the word being repaired wins over the scrubber.
      host_cycle(1, 0, 0, 0, 4'd0, 8'h11, '0, "h_wr0");
      host_cycle(0, 1, 0, 0, 4'd0, '0, 13'h004, "h_inj0");
      scrub_en = 1;
      wait_busy("hostfix");
      @(posedge clk); #1;
      m_corr = sat(m_corr + 1);
      chk_counters("hostfix.pre");
      host_cycle(1, 0, 0, 0, 4'd0, 8'h77, '0, "hostfix_wr");
      scrub_en = 0;
      repeat (2) @(posedge clk);
      #1;
      host_cycle(0, 0, 1, 0, 4'd0, '0, '0, "hostfix_rd0");

      // Random host traffic, at most two flipped bits per word.
      for (int n = 0; n < 300; n++) begin
         logic          w, i, r, c;
         logic [AW-1:0] a;
         logic [CW-1:0] m;
         a = AW'($urandom_range(0, DEPTH - 1));
         w = ($urandom_range(0, 4) == 0);
         i = ($urandom_range(0, 2) == 0);
         r = ($urandom_range(0, 1) == 0);
         c = ($urandom_range(0, 7) == 0);
         m = CW'(1) << $urandom_range(0, CW - 1);
         if (!w && i && $countones(m_flip[a]) >= 2) i = 0;
         host_cycle(w, i, r, c, a, DATA_W'($urandom), m, $sformatf("rand%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
